// File: rtl/cmd_phys_layer.sv
// cmd_phys_layer
//   CMD-line physical layer for the SD host, sitting directly after control_cmd.
//   It takes a 40-bit command head, appends the CRC7 and the end bit, and shifts
//   the 48-bit frame out onto CMD, MSB first. It then captures a 48-bit or
//   136-bit card response, or flags a timeout if the card stays silent. The
//   result goes back to the control stage through a strobe/ack handshake.
//
// Parameters
//   RESP_TIMEOUT  cycles allowed in WAIT_RESP for a start bit before time_out
//   CNT_W         width of the bit and timeout counters (holds 136 and RESP_TIMEOUT)
//
// Ports
//   clock         system clock, all logic on posedge
//   reset         synchronous, active-low reset
//   strobe_in     command request from the control stage
//   ack_in        control stage has consumed the result
//   idle_in       abort/park request from the control stage
//   cmd_to_send   {start=0, dir=1, index[5:0], arg[31:0]}
//   cmd_pin_in    sampled CMD line from the card
//   cmd_pin_out   CMD line drive value
//   cmd_oe        CMD line output enable
//   strobe_out    result valid
//   ack_out       handshake ack
//   cmd_response  captured response
//   time_out      no start bit arrived within RESP_TIMEOUT
//   crc_error     CRC7 mismatch on a 48-bit response
module cmd_phys_layer #(
  parameter int RESP_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         strobe_in,
  input  logic         ack_in,
  input  logic         idle_in,
  input  logic [39:0]  cmd_to_send,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  output logic         strobe_out,
  output logic         ack_out,
  output logic [127:0] cmd_response,
  output logic         time_out,
  output logic         crc_error
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(48);
  localparam logic [CNT_W-1:0] LONG_BITS  = CNT_W'(136);
  localparam logic [CNT_W-1:0] TOUT_LIMIT = CNT_W'(RESP_TIMEOUT);

  state_t             state;
  logic [47:0]        tx_sr;
  logic [135:0]       rx_sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   tout_cnt;
  logic               resp_none;
  logic               resp_long;

  logic [5:0]         req_index;
  logic [47:0]        req_frame;
  logic [135:0]       rx_next;
  logic [CNT_W-1:0]   bit_cnt_inc;
  logic [CNT_W-1:0]   tout_cnt_inc;
  logic [CNT_W-1:0]   rx_target;
  logic [6:0]         rx_crc;

  // Serial CRC7, G(x) = x^7 + x^3 + 1, init 0, one data bit per iteration MSB first.
  function automatic logic [6:0] crc7_40(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb     = data[i] ^ crc[6];
      crc    = {crc[5:0], 1'b0};
      crc[0] = fb;
      crc[3] = crc[3] ^ fb;
    end
    return crc;
  endfunction

  // The whole outgoing frame is built at accept time so SEND only has to shift.
  // The counter increments saturate instead of wrapping.
  always_comb begin
    req_index    = cmd_to_send[37:32];
    req_frame    = {cmd_to_send, crc7_40(cmd_to_send), 1'b1};
    rx_next      = {rx_sr[134:0], cmd_pin_in};
    bit_cnt_inc  = (bit_cnt == '1) ? bit_cnt : bit_cnt + CNT_ONE;
    tout_cnt_inc = (tout_cnt == '1) ? tout_cnt : tout_cnt + CNT_ONE;
    rx_target    = resp_long ? LONG_BITS : FRAME_BITS;
    rx_crc       = crc7_40(rx_next[47:8]);
  end

  // Main controller. All outputs are registered here. In SEND, bit_cnt counts
  // the bits already on the pin, so the first bit goes out on the accept edge.
  // In WAIT_RESP the start-bit test comes before the timeout test, so a start
  // bit on the limit edge wins. idle_in aborts every active state except DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cmd_pin_out  <= 1'b1;
      cmd_oe       <= 1'b0;
      strobe_out   <= 1'b0;
      ack_out      <= 1'b0;
      cmd_response <= '0;
      time_out     <= 1'b0;
      crc_error    <= 1'b0;
      bit_cnt      <= '0;
      tout_cnt     <= '0;
      tx_sr        <= '1;
      rx_sr        <= '0;
      resp_none    <= 1'b0;
      resp_long    <= 1'b0;
    end else if (idle_in && (state == SEND || state == WAIT_RESP || state == RECEIVE)) begin
      state       <= IDLE;
      cmd_oe      <= 1'b0;
      cmd_pin_out <= 1'b1;
      bit_cnt     <= '0;
      tout_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_in && !idle_in) begin
            tx_sr        <= {req_frame[46:0], 1'b1};
            cmd_pin_out  <= req_frame[47];
            cmd_oe       <= 1'b1;
            bit_cnt      <= CNT_ONE;
            tout_cnt     <= '0;
            resp_none    <= (req_index == 6'd0);
            resp_long    <= (req_index == 6'd2) || (req_index == 6'd9) || (req_index == 6'd10);
            time_out     <= 1'b0;
            crc_error    <= 1'b0;
            cmd_response <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt < FRAME_BITS) begin
            cmd_pin_out <= tx_sr[47];
            tx_sr       <= {tx_sr[46:0], 1'b1};
            bit_cnt     <= bit_cnt_inc;
          end else begin
            cmd_oe      <= 1'b0;
            cmd_pin_out <= 1'b1;
            bit_cnt     <= '0;
            tout_cnt    <= '0;
            if (resp_none) begin
              strobe_out <= 1'b1;
              ack_out    <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (!cmd_pin_in) begin
            rx_sr   <= '0;
            bit_cnt <= CNT_ONE;
            state   <= RECEIVE;
          end else if (tout_cnt_inc >= TOUT_LIMIT) begin
            tout_cnt     <= tout_cnt_inc;
            time_out     <= 1'b1;
            cmd_response <= '0;
            strobe_out   <= 1'b1;
            ack_out      <= 1'b1;
            state        <= DONE;
          end else begin
            tout_cnt <= tout_cnt_inc;
          end
        end
        RECEIVE: begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt_inc;
          if (bit_cnt_inc >= rx_target) begin
            if (resp_long) begin
              cmd_response <= rx_next[127:0];
              crc_error    <= 1'b0;
            end else begin
              cmd_response <= {80'b0, rx_next[47:0]};
              crc_error    <= (rx_crc != rx_next[7:1]);
            end
            strobe_out <= 1'b1;
            ack_out    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (ack_in) begin
            strobe_out <= 1'b0;
            ack_out    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_phys_layer.sv
// tb_cmd_phys_layer
//   Self-checking bench for cmd_phys_layer. Expected frames, response latency
//   and result fields come from a behavioural model. The model uses polynomial
//   long division for CRC7 and computes timing from the card delay plus the
//   response length. The bench plays the card on cmd_pin_in. Inputs are driven
//   and outputs are sampled on the falling edge.
module tb_cmd_phys_layer;

  localparam int RESP_TIMEOUT = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         strobe_in;
  logic         ack_in;
  logic         idle_in;
  logic [39:0]  cmd_to_send;
  logic         cmd_pin_in;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         strobe_out;
  logic         ack_out;
  logic [127:0] cmd_response;
  logic         time_out;
  logic         crc_error;

  int total = 0;
  int bad   = 0;

  logic [39:0]  d40;
  logic [135:0] rsp;
  logic [5:0]   rnd_idx;
  int           rnd_delay;
  int           flip_pos;

  cmd_phys_layer #(.RESP_TIMEOUT(RESP_TIMEOUT), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .strobe_in    (strobe_in),
    .ack_in       (ack_in),
    .idle_in      (idle_in),
    .cmd_to_send  (cmd_to_send),
    .cmd_pin_in   (cmd_pin_in),
    .cmd_pin_out  (cmd_pin_out),
    .cmd_oe       (cmd_oe),
    .strobe_out   (strobe_out),
    .ack_out      (ack_out),
    .cmd_response (cmd_response),
    .time_out     (time_out),
    .crc_error    (crc_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [135:0] got, input logic [135:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] model_crc7(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic int model_len(input logic [5:0] idx);
    if (idx == 6'd0) return 0;
    if (idx == 6'd2 || idx == 6'd9 || idx == 6'd10) return 136;
    return 48;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pin"},    cmd_pin_out,  1);
    checkOutput({tag, "_oe"},     cmd_oe,       0);
    checkOutput({tag, "_strobe"}, strobe_out,   0);
    checkOutput({tag, "_ack"},    ack_out,      0);
    checkOutput({tag, "_resp"},   cmd_response, 0);
    checkOutput({tag, "_to"},     time_out,     0);
    checkOutput({tag, "_crc"},    crc_error,    0);
  endtask

  // One complete command. The card waits `delay` cycles after CMD is released
  // and then sends `r` (its low len bits, MSB first).
  task automatic applyStimulus(input logic [39:0] cmd, input int delay, input logic [135:0] r,
                               input int ack_wait, input logic [47:0] fixed_frame,
                               input bit check_fixed, input bit rst_done);
    logic [47:0]  exp_frame, frame;
    logic [127:0] exp_resp;
    logic         exp_to, exp_crc;
    int           len, exp_k, k, oe_cnt, held;
    len       = model_len(cmd[37:32]);
    exp_frame = {cmd, model_crc7(cmd), 1'b1};
    if (len == 0) begin
      exp_k = 0; exp_to = 0; exp_crc = 0; exp_resp = '0;
    end else if (delay >= RESP_TIMEOUT) begin
      exp_k = RESP_TIMEOUT; exp_to = 1; exp_crc = 0; exp_resp = '0;
    end else begin
      exp_k  = delay + len;
      exp_to = 0;
      if (len == 136) begin
        exp_resp = r[127:0]; exp_crc = 0;
      end else begin
        exp_resp = {80'b0, r[47:0]};
        exp_crc  = (model_crc7(r[47:8]) != r[7:1]);
      end
    end

    @(negedge clock);
    cmd_to_send = cmd;
    strobe_in   = 1'b1;
    @(negedge clock);
    strobe_in   = 1'b0;
    cmd_to_send = 40'({$urandom, $urandom});
    frame  = '0;
    oe_cnt = 0;
    while (cmd_oe === 1'b1 && oe_cnt < 100) begin
      frame      = {frame[46:0], cmd_pin_out};
      oe_cnt++;
      strobe_in  = 1'($urandom);
      cmd_pin_in = 1'($urandom);
      @(negedge clock);
    end
    strobe_in  = 1'b0;
    checkOutput("oe_cycles", oe_cnt, 48);
    checkOutput("frame", frame, exp_frame);
    if (check_fixed) checkOutput("frame_const", frame, fixed_frame);
    checkOutput("pin_released", cmd_pin_out, 1);

    k = 0;
    while (strobe_out !== 1'b1 && k < 400) begin
      if (k < delay) cmd_pin_in = 1'b1;
      else if (k - delay < len) cmd_pin_in = r[len - 1 - (k - delay)];
      else cmd_pin_in = 1'b1;
      @(negedge clock);
      k++;
    end
    cmd_pin_in = 1'b1;
    checkOutput("strobe_latency", k, exp_k);
    checkOutput("ack_out", ack_out, 1);
    checkOutput("time_out", time_out, exp_to);
    checkOutput("crc_error", crc_error, exp_crc);
    checkOutput("cmd_response", cmd_response, exp_resp);

    if (rst_done) begin
      reset = 1'b0;
      @(negedge clock);
      checkResetValues("rst_done");
      reset = 1'b1;
    end else begin
      held = 0;
      for (int i = 0; i < ack_wait; i++) begin
        idle_in = 1'($urandom);
        @(negedge clock);
        if (strobe_out === 1'b1 && ack_out === 1'b1) held++;
      end
      idle_in = 1'b0;
      ack_in  = 1'b1;
      @(negedge clock);
      ack_in  = 1'b0;
      checkOutput("hold_cycles", held, ack_wait);
      checkOutput("strobe_clear", strobe_out, 0);
      checkOutput("ack_clear", ack_out, 0);
      checkOutput("resp_hold", cmd_response, exp_resp);
      checkOutput("to_hold", time_out, exp_to);
    end
  endtask

  task automatic abortInSend(input logic [39:0] cmd);
    int cnt;
    @(negedge clock);
    cmd_to_send = cmd;
    strobe_in   = 1'b1;
    @(negedge clock);
    strobe_in   = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("abort_oe_before", cmd_oe, 1);
    idle_in = 1'b1;
    @(negedge clock);
    idle_in = 1'b0;
    checkOutput("abort_oe", cmd_oe, 0);
    checkOutput("abort_pin", cmd_pin_out, 1);
    checkOutput("abort_strobe", strobe_out, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clock);
      if (strobe_out === 1'b1 || cmd_oe === 1'b1) cnt++;
    end
    checkOutput("abort_quiet", cnt, 0);
  endtask

  task automatic resetInReceive(input logic [39:0] cmd, input logic [47:0] r);
    int guard, cnt;
    @(negedge clock);
    cmd_to_send = cmd;
    strobe_in   = 1'b1;
    @(negedge clock);
    strobe_in   = 1'b0;
    guard = 0;
    while (cmd_oe === 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    for (int k = 0; k < 30; k++) begin
      cmd_pin_in = (k < 2) ? 1'b1 : r[47 - (k - 2)];
      @(negedge clock);
    end
    reset      = 1'b0;
    cmd_pin_in = 1'b1;
    @(negedge clock);
    checkResetValues("rst_receive");
    reset = 1'b1;
    cnt = 0;
    repeat (150) begin
      @(negedge clock);
      if (strobe_out === 1'b1) cnt++;
    end
    checkOutput("rst_quiet", cnt, 0);
  endtask

  initial begin
    reset       = 1'b0;
    strobe_in   = 1'b0;
    ack_in      = 1'b0;
    idle_in     = 1'b0;
    cmd_to_send = '0;
    cmd_pin_in  = 1'b1;
    repeat (3) @(negedge clock);
    checkResetValues("init");
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] CMD0, no response");
    applyStimulus(40'h4000000000, 0, '0, 2, 48'h400000000095, 1, 0);

    $display("[TB] CMD8 with good and corrupted response");
    d40 = {2'b00, 6'd8, 32'h000001AA};
    rsp = {88'b0, d40, model_crc7(d40), 1'b1};
    applyStimulus(40'h48000001AA, 5, rsp, 1, 48'h48000001AA87, 1, 0);
    rsp[20] = ~rsp[20];
    applyStimulus(40'h48000001AA, 3, rsp, 0, 48'h48000001AA87, 1, 0);
    applyStimulus(40'h48000001AA, 0, rsp, 0, 48'h48000001AA87, 1, 1);

    $display("[TB] CMD17 timeout boundaries");
    d40 = {2'b00, 6'd17, 32'h00000900};
    rsp = {88'b0, d40, model_crc7(d40), 1'b1};
    applyStimulus({2'b01, 6'd17, 32'h00001234}, 1000, rsp, 1, '0, 0, 0);
    applyStimulus({2'b01, 6'd17, 32'h00001234}, 63, rsp, 1, '0, 0, 0);
    applyStimulus({2'b01, 6'd17, 32'h00001234}, 64, rsp, 1, '0, 0, 0);

    $display("[TB] CMD2 long response with held ack");
    rsp = {8'h3F, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211};
    applyStimulus({2'b01, 6'd2, 32'h0}, 2, rsp, 10, '0, 0, 0);

    $display("[TB] abort and reset");
    abortInSend({2'b01, 6'd17, 32'hDEADBEEF});
    d40 = {2'b00, 6'd17, 32'h00000A00};
    resetInReceive({2'b01, 6'd17, 32'h00000100}, {d40, model_crc7(d40), 1'b1});
    applyStimulus(40'h4000000000, 0, '0, 0, 48'h400000000095, 1, 0);

    $display("[TB] random commands");
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: rnd_idx = 6'd0;
          1: rnd_idx = 6'd2;
          2: rnd_idx = 6'd9;
          default: rnd_idx = 6'd10;
        endcase
      end else begin
        rnd_idx = 6'($urandom_range(0, 63));
      end
      if (model_len(rnd_idx) == 136) begin
        rsp = {8'h3F, $urandom, $urandom, $urandom, $urandom};
      end else begin
        d40 = {2'b00, 6'($urandom), $urandom};
        rsp = {88'b0, d40, model_crc7(d40), 1'b1};
        if ($urandom_range(0, 2) == 0) begin
          flip_pos = $urandom_range(1, 46);
          rsp[flip_pos] = ~rsp[flip_pos];
        end
      end
      case ($urandom_range(0, 3))
        0: rnd_delay = $urandom_range(0, 10);
        1: rnd_delay = $urandom_range(60, 63);
        2: rnd_delay = $urandom_range(64, 70);
        default: rnd_delay = $urandom_range(0, 63);
      endcase
      applyStimulus({2'b01, rnd_idx, $urandom}, rnd_delay, rsp, $urandom_range(0, 4), '0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
